// File: rtl/game_state_ctrl.sv
// Game-flow sequencer for the VGA path: title/play/respawn/clear/game-over phases,
// lives and level counters, per-phase frame timers and banner blink, all outputs registered.
//
// state      | meaning
// S_TITLE    | title screen, waits for start key after minimum display time
// S_PLAY     | objects active, reacts to hit / cleared / landed events
// S_RESPAWN  | frozen after a hit, timed return to play
// S_CLEAR    | level-clear banner, timed advance to next level
// S_GAMEOVER | game-over screen, waits for key after minimum display time
module game_state_ctrl #(
  parameter int LIVES            = 3,
  parameter int MAX_LEVEL        = 7,
  parameter int TITLE_MIN_FRAMES = 30,
  parameter int RESPAWN_FRAMES   = 60,
  parameter int CLEAR_FRAMES     = 120,
  parameter int GAMEOVER_FRAMES  = 180,
  parameter int BLINK_FRAMES     = 16
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startKey,
  input  logic       playerHit,
  input  logic       aliensCleared,
  input  logic       invadersLanded,
  output logic [1:0] screenSel,
  output logic       playEnable,
  output logic       levelStartPulse,
  output logic [2:0] level,
  output logic [1:0] lives,
  output logic       blinkOn,
  output logic       gameover
);

  typedef enum logic [2:0] {
    S_TITLE,
    S_PLAY,
    S_RESPAWN,
    S_CLEAR,
    S_GAMEOVER
  } state_t;

  localparam logic [7:0] TITLE_MIN_C  = 8'(TITLE_MIN_FRAMES);
  localparam logic [7:0] RESPAWN_C    = 8'(RESPAWN_FRAMES);
  localparam logic [7:0] CLEAR_C      = 8'(CLEAR_FRAMES);
  localparam logic [7:0] GAMEOVER_C   = 8'(GAMEOVER_FRAMES);
  localparam logic [7:0] BLINK_LAST_C = 8'(BLINK_FRAMES - 1);
  localparam logic [2:0] MAX_LEVEL_C  = 3'(MAX_LEVEL);
  localparam logic [1:0] LIVES_C      = 2'(LIVES);

  state_t      state_q, state_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  blink_cnt_q, blink_cnt_d;
  logic        blink_on_q, blink_on_d;
  logic        key_q;
  logic [1:0]  lives_q, lives_d;
  logic [2:0]  level_q, level_d;
  logic        lsp_q, lsp_d;
  logic [1:0]  screen_sel_q, screen_sel_d;
  logic        play_en_q, play_en_d;
  logic        gameover_q, gameover_d;
  logic        key_edge;

  always_comb begin
    key_edge = startKey & ~key_q;
    state_d  = state_q;
    lives_d  = lives_q;
    level_d  = level_q;
    lsp_d    = 1'b0;

    case (state_q)
      S_TITLE: begin
        if (key_edge && (frame_cnt_q >= TITLE_MIN_C)) begin
          lives_d = LIVES_C;
          level_d = 3'd0;
          lsp_d   = 1'b1;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        // landed beats hit beats cleared when events coincide
        if (invadersLanded) begin
          lives_d = 2'd0;
          state_d = S_GAMEOVER;
        end else if (playerHit) begin
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = S_GAMEOVER;
          end else begin
            lives_d = lives_q - 2'd1;
            state_d = S_RESPAWN;
          end
        end else if (aliensCleared) begin
          state_d = S_CLEAR;
        end
      end
      S_RESPAWN: begin
        if (frame_cnt_q >= RESPAWN_C) state_d = S_PLAY;
      end
      S_CLEAR: begin
        if (frame_cnt_q >= CLEAR_C) begin
          if (level_q < MAX_LEVEL_C) level_d = level_q + 3'd1;
          lsp_d   = 1'b1;
          state_d = S_PLAY;
        end
      end
      S_GAMEOVER: begin
        if (key_edge && (frame_cnt_q >= GAMEOVER_C)) state_d = S_TITLE;
      end
      default: state_d = S_TITLE;
    endcase

    // a frame pulse coinciding with a transition is lost to the entry clear
    frame_cnt_d = frame_cnt_q;
    if (state_d != state_q) begin
      frame_cnt_d = 8'd0;
    end else if (startOfFrame && (frame_cnt_q != 8'hFF)) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (startOfFrame) begin
      if (blink_cnt_q >= BLINK_LAST_C) begin
        blink_cnt_d = 8'd0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end

    screen_sel_d = 2'd1;
    play_en_d    = 1'b0;
    gameover_d   = 1'b0;
    case (state_d)
      S_TITLE:    screen_sel_d = 2'd1;
      S_PLAY: begin
        screen_sel_d = 2'd0;
        play_en_d    = 1'b1;
      end
      S_RESPAWN:  screen_sel_d = 2'd0;
      S_CLEAR:    screen_sel_d = 2'd2;
      S_GAMEOVER: begin
        screen_sel_d = 2'd3;
        gameover_d   = 1'b1;
      end
      default:    screen_sel_d = 2'd1;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_TITLE;
      frame_cnt_q  <= 8'd0;
      blink_cnt_q  <= 8'd0;
      blink_on_q   <= 1'b0;
      key_q        <= 1'b0;
      lives_q      <= 2'd0;
      level_q      <= 3'd0;
      lsp_q        <= 1'b0;
      screen_sel_q <= 2'd1;
      play_en_q    <= 1'b0;
      gameover_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      key_q        <= startKey;
      lives_q      <= lives_d;
      level_q      <= level_d;
      lsp_q        <= lsp_d;
      screen_sel_q <= screen_sel_d;
      play_en_q    <= play_en_d;
      gameover_q   <= gameover_d;
    end
  end

  assign screenSel       = screen_sel_q;
  assign playEnable      = play_en_q;
  assign levelStartPulse = lsp_q;
  assign level           = level_q;
  assign lives           = lives_q;
  assign blinkOn         = blink_on_q;
  assign gameover        = gameover_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed game flow with randomized frame spacing and ignored-event noise,
// checked every cycle against a phase-level reference model.
module tb_game_state_ctrl;

  localparam int PH_TITLE = 0, PH_PLAY = 1, PH_RESPAWN = 2, PH_CLEAR = 3, PH_OVER = 4;

  logic       clk = 1'b0;
  logic       resetN, sof, key, hit, clr, land;
  logic [1:0] screenSel, lives;
  logic       playEnable, levelStartPulse, blinkOn, gameover;
  logic [2:0] level;

  always #5 clk = ~clk;

  game_state_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .startKey(key),
    .playerHit(hit), .aliensCleared(clr), .invadersLanded(land),
    .screenSel(screenSel), .playEnable(playEnable), .levelStartPulse(levelStartPulse),
    .level(level), .lives(lives), .blinkOn(blinkOn), .gameover(gameover)
  );

  int errors = 0;
  int checks = 0;

  // reference model: phase, frames since phase entry, frames since reset
  int m_ph, m_fc, m_lives, m_level, m_frames;
  bit m_lsp, m_prev_key;
  int sof_gap;

  function automatic void model_reset();
    m_ph = PH_TITLE; m_fc = 0; m_lives = 0; m_level = 0; m_frames = 0;
    m_lsp = 0; m_prev_key = 0;
  endfunction

  task automatic model_step();
    bit kedge;
    int nph;
    if (!resetN) begin
      model_reset();
      return;
    end
    kedge = key && !m_prev_key;
    m_prev_key = key;
    nph = m_ph;
    m_lsp = 0;
    case (m_ph)
      PH_TITLE: if (kedge && m_fc >= 30) begin
        m_lives = 3; m_level = 0; m_lsp = 1; nph = PH_PLAY;
      end
      PH_PLAY: begin
        if (land) begin m_lives = 0; nph = PH_OVER; end
        else if (hit) begin
          if (m_lives <= 1) begin m_lives = 0; nph = PH_OVER; end
          else begin m_lives = m_lives - 1; nph = PH_RESPAWN; end
        end else if (clr) nph = PH_CLEAR;
      end
      PH_RESPAWN: if (m_fc >= 60) nph = PH_PLAY;
      PH_CLEAR: if (m_fc >= 120) begin
        m_level = (m_level + 1 > 7) ? 7 : m_level + 1;
        m_lsp = 1; nph = PH_PLAY;
      end
      PH_OVER: if (kedge && m_fc >= 180) nph = PH_TITLE;
      default: nph = PH_TITLE;
    endcase
    if (nph != m_ph) m_fc = 0;
    else if (sof && m_fc < 255) m_fc = m_fc + 1;
    m_ph = nph;
    if (sof) m_frames = m_frames + 1;
  endtask

  function automatic logic [10:0] expected();
    logic [1:0] sel;
    case (m_ph)
      PH_TITLE: sel = 2'd1;
      PH_CLEAR: sel = 2'd2;
      PH_OVER:  sel = 2'd3;
      default:  sel = 2'd0;
    endcase
    return {sel, (m_ph == PH_PLAY), m_lsp, 3'(m_level), 2'(m_lives),
            ((m_frames / 16) % 2) == 1, (m_ph == PH_OVER)};
  endfunction

  function automatic logic [10:0] observed();
    return {screenSel, playEnable, levelStartPulse, level, lives, blinkOn, gameover};
  endfunction

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic do_cycle();
    sof = (sof_gap == 0);
    if (sof_gap == 0) sof_gap = $urandom_range(1, 4);
    else sof_gap--;
    @(posedge clk);
    model_step();
    #1;
    chk("cycle", observed(), expected());
    hit = 0; clr = 0; land = 0;
  endtask

  // events and key activity that the current phase must ignore
  task automatic noise();
    if (m_ph == PH_RESPAWN || m_ph == PH_CLEAR) begin
      hit  = ($urandom_range(0, 5) == 0);
      clr  = ($urandom_range(0, 5) == 0);
      land = ($urandom_range(0, 5) == 0);
      key  = $urandom_range(0, 1);
    end else begin
      key = 0;
    end
  endtask

  task automatic run_until_fc(input int n, input string tag);
    int c = 0;
    while (m_fc < n && c < 3000) begin noise(); do_cycle(); c++; end
    chk(tag, 11'(c < 3000), 11'd1);
  endtask

  task automatic wait_phase(input int target, input string tag);
    int c = 0;
    while (m_ph != target && c < 3000) begin noise(); do_cycle(); c++; end
    chk(tag, 11'(c < 3000), 11'd1);
  endtask

  task automatic press_key();
    key = 0; do_cycle();
    key = 1; do_cycle();
    key = 0;
  endtask

  initial begin
    resetN = 0; sof = 0; key = 0; hit = 0; clr = 0; land = 0;
    sof_gap = 1;
    model_reset();
    repeat (3) do_cycle();
    chk("reset", observed(), 11'b01_0_0_000_00_0_0);
    resetN = 1;

    run_until_fc(10, "title_wait10");
    press_key();
    chk("title_early_key", 11'(screenSel), 11'd1);
    run_until_fc(30, "title_wait30");
    press_key();
    chk("start", {2'b0, screenSel, playEnable, levelStartPulse, lives, level},
        {2'b0, 2'd0, 1'b1, 1'b1, 2'd3, 3'd0});
    do_cycle();
    chk("start_pulse_once", 11'(levelStartPulse), 11'd0);

    hit = 1; do_cycle();
    chk("hit1", {7'b0, lives, playEnable, screenSel == 2'd0}, {7'b0, 2'd2, 1'b0, 1'b1});
    wait_phase(PH_PLAY, "respawn1_exit");
    chk("respawn1_no_pulse", {8'b0, playEnable, levelStartPulse, lives == 2'd2}, 11'b1_0_1);

    hit = 1; clr = 1; do_cycle();
    chk("hit_and_clear", {6'b0, screenSel, lives, playEnable}, {6'b0, 2'd0, 2'd1, 1'b0});
    wait_phase(PH_PLAY, "respawn2_exit");

    hit = 1; do_cycle();
    chk("last_hit", {6'b0, screenSel, gameover, lives}, {6'b0, 2'd3, 1'b1, 2'd0});

    run_until_fc(100, "over_wait100");
    press_key();
    chk("over_early_key", 11'(screenSel), 11'd3);
    run_until_fc(180, "over_wait180");
    press_key();
    chk("over_restart", {9'b0, screenSel}, {9'b0, 2'd1});

    run_until_fc(30, "title2_wait");
    press_key();
    land = 1; hit = 1; do_cycle();
    chk("land_and_hit", {6'b0, screenSel, gameover, lives}, {6'b0, 2'd3, 1'b1, 2'd0});
    run_until_fc(180, "over2_wait");
    press_key();
    run_until_fc(30, "title3_wait");
    press_key();
    chk("start3", {8'b0, playEnable, lives}, {8'b0, 1'b1, 2'd3});

    for (int i = 0; i < 8; i++) begin
      clr = 1; do_cycle();
      chk("clear_screen", 11'(screenSel), 11'd2);
      wait_phase(PH_PLAY, "clear_exit");
      chk("clear_level", {7'b0, level, levelStartPulse},
          {7'b0, 3'((i + 1 > 7) ? 7 : i + 1), 1'b1});
    end

    hit = 1; do_cycle();
    run_until_fc(20, "respawn3_wait");
    key = 0;
    #2 resetN = 0;
    #1;
    chk("async_reset", observed(), 11'b01_0_0_000_00_0_0);
    model_reset();
    repeat (2) do_cycle();
    resetN = 1;

    run_until_fc(20, "title4_wait20");
    press_key();
    chk("title_after_reset_early", 11'(screenSel), 11'd1);
    run_until_fc(30, "title4_wait30");
    press_key();
    chk("title_after_reset_ok", {8'b0, screenSel, playEnable}, {8'b0, 2'd0, 1'b1});
    repeat (40) do_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
